// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode and
// Funct fields, ALU operation codes and ALU B-operand selects.
package ctrl_pkg;

    localparam int OP_W  = 6;
    localparam int ALU_W = 4;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        ADDIEXEC = 4'd8,
        ADDIWB   = 4'd9,
        BRANCH   = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

    localparam logic [OP_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [OP_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [OP_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [OP_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [OP_W-1:0] FUNCT_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic is_supported_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational Funct -> ALUControl map for R-type instructions; unknown
// Funct values fall back to ADD.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  funct,
    output logic [ALU_W-1:0] alu_control
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
        alu_control = ALU_ADD;
        case (funct)
            FUNCT_SUB: alu_control = ALU_SUB;
            FUNCT_AND: alu_control = ALU_AND;
            FUNCT_OR:  alu_control = ALU_OR;
            FUNCT_SLT: alu_control = ALU_SLT;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, addi, beq).
// Define CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in HALT until reset.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int OP_WIDTH       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [OP_WIDTH-1:0]       OP,
    input  logic [OP_WIDTH-1:0]       Funct,
    input  logic                      Zero,
    output logic                      PCWrite,
    output logic                      IorD,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic                      RegDst,
    output logic                      MemtoReg,
    output logic                      RegWrite,
    output logic                      ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      PCSrc,
    output logic                      instr_done,
    output logic                      illegal_op
);

    state_t                    state;
    state_t                    state_next;
    logic [ALU_CTRL_WIDTH-1:0] funct_alu;

    alu_decoder u_alu_decoder (
        .funct       (Funct),
        .alu_control (funct_alu)
    );

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (OP)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_BEQ:       state_next = BRANCH;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_next = HALT;
`else
                        state_next = FETCH;
`endif
                    end
                endcase
            end
            // OP is still held by the IR here, so it picks the memory direction.
            MEMADR:   state_next = (OP == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = MEMWB;
            EXECUTE:  state_next = ALUWB;
            ADDIEXEC: state_next = ADDIWB;
            HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = HALT;
`else
                state_next = FETCH;
`endif
            end
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // Outputs decode the current state; holding reset low forces every strobe to its default.
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        PCSrc      = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                end
                DECODE: begin
                    ALUSrcB    = SRCB_IMM_SH;
                    illegal_op = !is_supported_op(OP);
                end
                MEMADR, ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMREAD:  IorD = 1'b1;
                MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = funct_alu;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSrc      = 1'b1;
                    PCWrite    = Zero;
                    instr_done = 1'b1;
                end
                HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
